// File: rtl/ray_scheduler_if.sv
// Camera snapshot type and the scheduler <-> ray generator/tracer interface.
// The master side is the scheduler; the slave side is the generator/tracer pipeline.
package ray_scheduler_pkg;

  typedef struct packed {
    logic [15:0] pos_x;
    logic [15:0] pos_y;
    logic [15:0] pos_z;
    logic [15:0] yaw;
    logic [15:0] pitch;
    logic [15:0] fov;
  } camera_t;

endpackage

interface ray_gen_if;
  import ray_scheduler_pkg::*;

  camera_t     cam_out;
  logic [10:0] pixel_h_out;
  logic [9:0]  pixel_v_out;
  logic        new_ray;
  logic        ray_valid_in;
  logic [10:0] rt_pixel_h;
  logic [9:0]  rt_pixel_v;
  logic        credit_return;

  modport master (
    output cam_out, pixel_h_out, pixel_v_out, new_ray, rt_pixel_h, rt_pixel_v,
    input  ray_valid_in, credit_return
  );

  modport slave (
    input  cam_out, pixel_h_out, pixel_v_out, new_ray, rt_pixel_h, rt_pixel_v,
    output ray_valid_in, credit_return
  );

endinterface

// File: rtl/ray_scheduler.sv
// Frame controller: latches the camera, scans pixels in raster order under a credit
// limit, and queues coordinates so they re-attach to the generator's ray_valid.
module ray_scheduler
  import ray_scheduler_pkg::*;
#(
  parameter int WIDTH        = 1280,
  parameter int HEIGHT       = 720,
  parameter int MAX_INFLIGHT = 16,
  parameter int TAG_DEPTH    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  camera_t       cam_in,
  ray_gen_if.master     rg,
  output logic          busy,
  output logic          frame_done,
  output logic          tag_error
);

  localparam int          AW      = $clog2(TAG_DEPTH);
  localparam logic [10:0] H_LAST  = 11'(WIDTH - 1);
  localparam logic [9:0]  V_LAST  = 10'(HEIGHT - 1);
  localparam logic [5:0]  MAX_IF  = 6'(MAX_INFLIGHT);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [10:0] h_q;
  logic [9:0]  v_q;
  logic [5:0]  inflight_q, inflight_d;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [20:0] tag_mem [TAG_DEPTH];

  logic fifo_empty, fifo_full;
  logic issue, accept, done_d, credit_ok, pop, err_d;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Issue is gated on !fifo_full, so a push can never meet a full FIFO.
  assign pop       = rg.ray_valid_in && !fifo_empty;
  assign credit_ok = rg.credit_return && (inflight_q != 6'd0);
  assign err_d     = (rg.ray_valid_in && fifo_empty) ||
                     (rg.credit_return && (inflight_q == 6'd0));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d    = state_q;
    accept     = 1'b0;
    done_d     = 1'b0;
    issue      = (state_q == ISSUE) && (inflight_q < MAX_IF) && !fifo_full;
    inflight_d = inflight_q;

    if (issue && !credit_ok)      inflight_d = inflight_q + 6'd1;
    else if (!issue && credit_ok) inflight_d = inflight_q - 6'd1;

    unique case (state_q)
      IDLE: begin
        // frame_done is still high in the first IDLE cycle; a start there is dropped.
        if (start && !frame_done) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue && (h_q == H_LAST) && (v_q == V_LAST)) state_d = DRAIN;
      end
      DRAIN: begin
        if (inflight_d == 6'd0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rg.cam_out     <= '0;
      rg.pixel_h_out <= '0;
      rg.pixel_v_out <= '0;
      rg.new_ray     <= 1'b0;
      h_q            <= '0;
      v_q            <= '0;
      inflight_q     <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      tag_error      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      rg.new_ray <= issue;
      frame_done <= done_d;

      if (accept) begin
        rg.cam_out <= cam_in;
        h_q        <= '0;
        v_q        <= '0;
        busy       <= 1'b1;
      end else if (done_d) begin
        busy <= 1'b0;
      end

      if (issue) begin
        rg.pixel_h_out <= h_q;
        rg.pixel_v_out <= v_q;
        if (h_q == H_LAST) begin
          h_q <= '0;
          v_q <= v_q + 10'd1;
        end else begin
          h_q <= h_q + 11'd1;
        end
      end

      if (issue) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      if (err_d) tag_error <= 1'b1;
    end
  end

  // NOTE: the coordinate storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (issue) tag_mem[wr_ptr[AW-1:0]] <= {h_q, v_q};
  end

  assign {rg.rt_pixel_h, rg.rt_pixel_v} = tag_mem[rd_ptr[AW-1:0]];

endmodule
